// File: rtl/sc_stream_decoder.sv
// Stochastic stream decoder: counts the ones in a unipolar bit stream of
// STREAM_LENGTH bits and presents the total through a valid/ready handshake.
module sc_stream_decoder #(
    parameter int unsigned STREAM_LENGTH = 16,
    parameter int unsigned CW            = $clog2(STREAM_LENGTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic          bit_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count_out,
    output logic          busy,
    output logic          start_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // Index of the final bit; its acceptance closes the stream.
    localparam logic [CW-1:0] LAST_IDX = CW'(STREAM_LENGTH - 1);

    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] bit_cnt_q,   bit_cnt_d;
    logic [CW-1:0] ones_cnt_q,  ones_cnt_d;
    logic [CW-1:0] count_q,     count_d;
    logic          start_err_q, start_err_d;

    logic          bit_accept;

    assign bit_accept = (state_q == ACCUM) && bit_valid;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            ones_cnt_q  <= '0;
            count_q     <= '0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            count_q     <= count_d;
            start_err_q <= start_err_d;
        end
    end

    // Next-state, counter and result logic.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        count_d     = count_q;
        start_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                end
            end

            ACCUM: begin
                // A new request cannot preempt a stream in progress.
                if (start) begin
                    start_err_d = 1'b1;
                end
                if (bit_accept) begin
                    bit_cnt_d  = bit_cnt_q + CW'(1);
                    ones_cnt_d = ones_cnt_q + CW'(bit_in);
                    if (bit_cnt_q == LAST_IDX) begin
                        state_d = HOLD;
                        count_d = ones_cnt_q + CW'(bit_in);
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    // Handshake with a concurrent start chains straight into the next stream.
                    if (start) begin
                        state_d    = ACCUM;
                        bit_cnt_d  = '0;
                        ones_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    start_err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are either registers or pure decodes of the state register.
    assign bit_ready = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign count_out = count_q;
    assign start_err = start_err_q;

endmodule
